instruction_fetch: RTL

//  Clocked consumer at the far end of the program counter's req/ack channel.
//  - Synchronises the self-timed address request.
//  - Reads the program memory and splits the word into MC14500B opcode + operand.
//  - Hands the instruction downstream on a 4-phase req/ack and acknowledges upstream.
//  - Sits between the program counter and the instruction decode/ALU stage.

---
 rtl/instruction_fetch.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module      : instruction_fetch
// Description : Clocked fetch stage. Synchronises the program counter's
//               request, reads program memory, splits the word into an
//               MC14500B opcode/operand and offers it downstream on a
//               4-phase req/ack handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_fetch #(
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_prev,
    output logic                  ack_prev,
    input  logic [ADDR_WIDTH-1:0] address_in,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_en,
    input  logic [DATA_WIDTH-1:0] mem_data,
    output logic [3:0]            opcode,
    output logic [DATA_WIDTH-5:0] operand,
    output logic                  req_next,
    input  logic                  ack_next
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_LATCH = 3'd2,
        S_OFFER = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    logic [SYNC_STAGES-1:0] r_req_sync;
    logic [SYNC_STAGES-1:0] r_ack_sync;
    logic                   w_req_s;
    logic                   w_ack_s;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [ADDR_WIDTH-1:0]  r_mem_addr;
    logic [ADDR_WIDTH-1:0]  w_mem_addr_nxt;
    logic                   r_mem_en;
    logic                   w_mem_en_nxt;
    logic [3:0]             r_opcode;
    logic [3:0]             w_opcode_nxt;
    logic [DATA_WIDTH-5:0]  r_operand;
    logic [DATA_WIDTH-5:0]  w_operand_nxt;
    logic                   r_req_next;
    logic                   w_req_next_nxt;
    logic                   r_ack_prev;
    logic                   w_ack_prev_nxt;

    // Both handshake inputs come from other timing domains.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_req_sync <= '0;
            r_ack_sync <= '0;
        end else begin
            r_req_sync <= {r_req_sync[SYNC_STAGES-2:0], req_prev};
            r_ack_sync <= {r_ack_sync[SYNC_STAGES-2:0], ack_next};
        end
    end

    assign w_req_s = r_req_sync[SYNC_STAGES-1];
    assign w_ack_s = r_ack_sync[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_mem_addr <= '0;
            r_mem_en   <= 1'b0;
            r_opcode   <= '0;
            r_operand  <= '0;
            r_req_next <= 1'b0;
            r_ack_prev <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_mem_addr <= w_mem_addr_nxt;
            r_mem_en   <= w_mem_en_nxt;
            r_opcode   <= w_opcode_nxt;
            r_operand  <= w_operand_nxt;
            r_req_next <= w_req_next_nxt;
            r_ack_prev <= w_ack_prev_nxt;
        end
    end

    // Outputs are computed for the state being entered, so each is a flop.
    always_comb begin
        w_state_nxt    = r_state;
        w_mem_addr_nxt = r_mem_addr;
        w_mem_en_nxt   = 1'b0;
        w_opcode_nxt   = r_opcode;
        w_operand_nxt  = r_operand;
        w_req_next_nxt = r_req_next;
        w_ack_prev_nxt = r_ack_prev;
        case (r_state)
            S_IDLE: begin
                if (w_req_s) begin
                    w_mem_addr_nxt = address_in;
                    w_mem_en_nxt   = 1'b1;
                    w_state_nxt    = S_FETCH;
                end
            end
            S_FETCH: begin
                w_state_nxt = S_LATCH;
            end
            S_LATCH: begin
                w_opcode_nxt   = mem_data[DATA_WIDTH-1 -: 4];
                w_operand_nxt  = mem_data[DATA_WIDTH-5:0];
                w_req_next_nxt = 1'b1;
                w_ack_prev_nxt = 1'b1;
                w_state_nxt    = S_OFFER;
            end
            S_OFFER: begin
                if (w_ack_s) begin
                    w_req_next_nxt = 1'b0;
                    w_state_nxt    = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Both sides must return to zero before the next request is seen.
                if (!w_req_s && !w_ack_s) begin
                    w_ack_prev_nxt = 1'b0;
                    w_state_nxt    = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign mem_addr = r_mem_addr;
    assign mem_en   = r_mem_en;
    assign opcode   = r_opcode;
    assign operand  = r_operand;
    assign req_next = r_req_next;
    assign ack_prev = r_ack_prev;

endmodule
`default_nettype wire
